// File: rtl/json_pkg.sv
// Shared definitions for the JSON pair scanner: 4-bit FSM state codes,
// the ASCII tokens the grammar recognises, and the whitespace classifier.
package json_pkg;

  localparam logic [3:0] S_IDLE      = 4'd0;
  localparam logic [3:0] S_OPEN      = 4'd1;
  localparam logic [3:0] S_KEY0      = 4'd2;
  localparam logic [3:0] S_KEY       = 4'd3;
  localparam logic [3:0] S_COLON     = 4'd4;
  localparam logic [3:0] S_VAL_START = 4'd5;
  localparam logic [3:0] S_VAL       = 4'd6;
  localparam logic [3:0] S_AFTER_VAL = 4'd7;
  localparam logic [3:0] S_NEXT_KEY  = 4'd8;
  localparam logic [3:0] S_ERR       = 4'd9;

  localparam logic [7:0] LBRACE = 8'h7B;
  localparam logic [7:0] RBRACE = 8'h7D;
  localparam logic [7:0] QUOTE  = 8'h22;
  localparam logic [7:0] COLON  = 8'h3A;
  localparam logic [7:0] COMMA  = 8'h2C;

  localparam logic [7:0] WS_SP  = 8'h20;
  localparam logic [7:0] WS_TAB = 8'h09;
  localparam logic [7:0] WS_LF  = 8'h0A;
  localparam logic [7:0] WS_CR  = 8'h0D;

  function automatic logic is_ws(input logic [7:0] c);
    return c inside {WS_SP, WS_TAB, WS_LF, WS_CR};
  endfunction

endpackage

// File: rtl/json_pair_scanner_if.sv
// Character stream in, scan results out. The source drives the master side,
// the scanner sits on the slave side.
interface json_pair_scanner_if #(
  parameter int CNT_W     = 8,
  parameter int MAX_DEPTH = 4,
  localparam int DEPTH_W  = $clog2(MAX_DEPTH + 1)
);
  logic               in_valid;
  logic [7:0]         in_char;
  logic [CNT_W-1:0]   cur_num;
  logic [CNT_W-1:0]   max_num;
  logic [CNT_W-1:0]   obj_cnt;
  logic [DEPTH_W-1:0] depth;
  logic [3:0]         state;
  logic               error;

  modport master (
    output in_valid, in_char,
    input  cur_num, max_num, obj_cnt, depth, state, error
  );

  modport slave (
    input  in_valid, in_char,
    output cur_num, max_num, obj_cnt, depth, state, error
  );
endinterface

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping; clear wins over inc.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clear,
  input  logic         inc,
  output logic [W-1:0] count
);

  // NOTE: registers are written with <= so every flop samples the pre-edge
  // value of its neighbours, which is what the hardware actually does.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      count <= '0;
    else if (clear)
      count <= '0;
    else if (inc && count != '1)
      count <= count + W'(1);
  end

endmodule

// File: rtl/json_pair_scanner.sv
// Streaming recogniser for a restricted JSON object grammar; counts key/value
// pairs per top-level object. Define JSON_NEST_EN to allow nested object values.
module json_pair_scanner
  import json_pkg::*;
#(
  parameter int CNT_W     = 8,
  parameter int MAX_DEPTH = 4,
  localparam int DEPTH_W  = $clog2(MAX_DEPTH + 1)
) (
  input  logic               clk,
  input  logic               reset,
  json_pair_scanner_if.slave bus
);

  logic [3:0]         state_q, state_nx;
  logic [DEPTH_W-1:0] depth_q, depth_nx;
  logic [CNT_W-1:0]   cur_num, obj_cnt, max_q;
  logic               err_q;
  logic               cur_inc, cur_clr, obj_inc, max_upd, do_close;
  logic               skip;
  logic [7:0]         c;

  assign c = bus.in_char;
  // Whitespace is only meaningful while inside a key or value string.
  assign skip = is_ws(c) && !(state_q inside {S_KEY0, S_KEY, S_VAL});

  // NOTE: every signal assigned here gets a default first, so no path leaves
  // one unassigned and no latch is inferred.
  always_comb begin
    state_nx = state_q;
    depth_nx = depth_q;
    cur_inc  = 1'b0;
    cur_clr  = 1'b0;
    obj_inc  = 1'b0;
    max_upd  = 1'b0;
    do_close = 1'b0;

    if (bus.in_valid && !skip) begin
      case (state_q)
        S_IDLE, S_ERR: begin
          if (c == LBRACE) begin
            state_nx = S_OPEN;
            depth_nx = DEPTH_W'(1);
            cur_clr  = 1'b1;
          end
        end
        S_OPEN: begin
          if (c == QUOTE)       state_nx = S_KEY0;
          else if (c == RBRACE) do_close = 1'b1;
          else                  state_nx = S_ERR;
        end
        S_KEY0:      state_nx = (c == QUOTE) ? S_ERR : S_KEY;
        S_KEY:       if (c == QUOTE) state_nx = S_COLON;
        S_COLON:     state_nx = (c == COLON) ? S_VAL_START : S_ERR;
        S_VAL_START: begin
          if (c == QUOTE)
            state_nx = S_VAL;
`ifdef JSON_NEST_EN
          else if (c == LBRACE && depth_q != DEPTH_W'(MAX_DEPTH)) begin
            state_nx = S_OPEN;
            depth_nx = depth_q + DEPTH_W'(1);
          end
`endif
          else
            state_nx = S_ERR;
        end
        S_VAL: begin
          if (c == QUOTE) begin
            state_nx = S_AFTER_VAL;
            cur_inc  = 1'b1;
          end
        end
        S_AFTER_VAL: begin
          if (c == COMMA)       state_nx = S_NEXT_KEY;
          else if (c == RBRACE) do_close = 1'b1;
          else                  state_nx = S_ERR;
        end
        S_NEXT_KEY:  state_nx = (c == QUOTE) ? S_KEY0 : S_ERR;
        default:     state_nx = S_ERR;
      endcase
    end

    // Closing the outermost object retires it; an inner close is one pair
    // of the enclosing object.
    if (do_close) begin
      depth_nx = depth_q - DEPTH_W'(1);
      if (depth_q == DEPTH_W'(1)) begin
        state_nx = S_IDLE;
        obj_inc  = 1'b1;
        max_upd  = 1'b1;
      end else begin
        state_nx = S_AFTER_VAL;
        cur_inc  = 1'b1;
      end
    end

    if (state_nx == S_ERR && state_q != S_ERR) begin
      cur_clr  = 1'b1;
      depth_nx = '0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      depth_q <= '0;
      err_q   <= 1'b0;
      max_q   <= '0;
    end else begin
      state_q <= state_nx;
      depth_q <= depth_nx;
      err_q   <= (state_nx == S_ERR);
      // cur_num is already final here: a close never increments it too.
      if (max_upd && cur_num > max_q)
        max_q <= cur_num;
    end
  end

  sat_counter #(.W(CNT_W)) u_cur_cnt (
    .clk   (clk),
    .rst_n (reset),
    .clear (cur_clr),
    .inc   (cur_inc),
    .count (cur_num)
  );

  sat_counter #(.W(CNT_W)) u_obj_cnt (
    .clk   (clk),
    .rst_n (reset),
    .clear (1'b0),
    .inc   (obj_inc),
    .count (obj_cnt)
  );

  assign bus.cur_num = cur_num;
  assign bus.obj_cnt = obj_cnt;
  assign bus.max_num = max_q;
  assign bus.depth   = depth_q;
  assign bus.state   = state_q;
  assign bus.error   = err_q;

endmodule

// File: doc/json_pair_scanner.md
Name: json_pair_scanner

Overview:
- Streaming JSON-object recogniser: consumes one ASCII char per valid cycle.
- Validates a restricted JSON grammar with nested objects.
- Counts key/value pairs in the current top-level object and tracks the maximum count over validly closed objects.
- Sits behind the character source in the text-parsing datapath; parametrised successor of the single-level pair counter, adding nesting, input qualification, whitespace skipping, error recovery and saturation.

Parameters:
- CNT_W, 8, width of cur_num/max_num/obj_cnt.
- MAX_DEPTH, 4, maximum object nesting depth (>=1).
- DEPTH_W, derived $clog2(MAX_DEPTH+1), depth port width (localparam).

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- in_valid  in  1  char qualifier; when 0 nothing changes.
- char  in  8  ASCII input.
- cur_num  out  CNT_W  completed pairs in current top-level object, all depths.
- max_num  out  CNT_W  max cur_num among validly closed top-level objects.
- obj_cnt  out  CNT_W  number of validly closed top-level objects.
- depth  out  DEPTH_W  current nesting depth.
- state  out  4  FSM state code.
- error  out  1  high while state==S_ERR.

Behaviour:
- Reset: asserting reset (reset==0) clears all outputs immediately, without waiting for a clock: cur_num=0, max_num=0, obj_cnt=0, depth=0, state=S_IDLE, error=0. This applies mid-object too.
- Timing: all outputs are registered. A char sampled at edge N is reflected in outputs right after edge N (1-cycle latency, no stalls).
- Whitespace (0x20,0x09,0x0A,0x0D) is ignored in every state except S_KEY0, S_KEY and S_VAL, where it is string content.
- State codes: S_IDLE 0, S_OPEN 1, S_KEY0 2, S_KEY 3, S_COLON 4, S_VAL_START 5, S_VAL 6, S_AFTER_VAL 7, S_NEXT_KEY 8, S_ERR 9.
- Transitions:
  - S_IDLE: '{' -> S_OPEN, depth=1, cur_num=0. Other chars ignored.
  - S_OPEN: '"' -> S_KEY0; '}' -> close.
  - S_KEY0: '"' -> S_ERR (empty key illegal); else -> S_KEY.
  - S_KEY: '"' -> S_COLON; else stay.
  - S_COLON: ':' -> S_VAL_START.
  - S_VAL_START: '"' -> S_VAL; '{' -> nest.
  - S_VAL: '"' -> S_AFTER_VAL, cur_num+1. Empty value is legal.
  - S_AFTER_VAL: ',' -> S_NEXT_KEY; '}' -> close.
  - S_NEXT_KEY: '"' -> S_KEY0.
  - Any char not listed, in states other than S_IDLE/S_ERR -> S_ERR.
- nest: if depth==MAX_DEPTH -> S_ERR; else depth+1, -> S_OPEN.
- close: depth-1.
  - If the new depth==0: obj_cnt+1, max_num=max(max_num,cur_num), -> S_IDLE, cur_num held.
  - Otherwise the inner object completes a pair of the enclosing object: cur_num+1, -> S_AFTER_VAL.
- S_ERR:
  - On entry: cur_num=0, depth=0; max_num/obj_cnt untouched.
  - While in S_ERR: '{' -> S_OPEN, depth=1, cur_num=0; all else ignored.
- Saturation: cur_num and obj_cnt saturate at 2^CNT_W-1, no wrap. max compare is unsigned.
- cur_num max-update and increment never coincide: the close uses the already-registered cur_num.

Optional Feature:
- JSON_NEST_EN defined: nested object values allowed, as above.
- JSON_NEST_EN undefined: '{' in S_VAL_START -> S_ERR; depth only ever 0/1; MAX_DEPTH ignored.

Decomposition:
- Package json_pkg: state enum/localparams S_* (4-bit), ASCII constants (LBRACE, RBRACE, QUOTE, COLON, COMMA, whitespace set), is_ws() function.
- One natural sub-module, sat_counter (parametrised width, inc, clear, saturating), instantiated for cur_num and obj_cnt.
- FSM and depth logic stay in the top module.

Test Plan:
- Reset then "{}" -> after '}': state=0, cur_num=0, max_num=0, obj_cnt=1, depth=0, error=0.
- {"k":"v","k":"v"} -> cur_num=1 after the 4th quote, 2 after the 8th; after '}': max_num=2, obj_cnt+1. A following {"k":"v"} ends with cur_num=1, max_num stays 2.
- {"":"v"} -> S_ERR (state=9, error=1) on the 2nd quote, cur_num=0, max_num unchanged. The next '{' -> state=1, error=0, then {"k":"v"} closes normally.
- With JSON_NEST_EN, MAX_DEPTH=2:
  - {"a":{"b":"c","d":"e"}} -> depth peaks 2, cur_num=3, max_num=3.
  - {"a":{"b":{ -> S_ERR at the third '{'.
  - Without the macro, {"a":{ -> S_ERR at the second '{'.
- Insert in_valid=0 cycles carrying garbage chars, plus spaces/newlines between tokens of a 2-pair object -> result identical to the clean stream (cur_num=2). reset low mid-object, between clock edges -> outputs zero immediately.
- CNT_W=2, object with 5 pairs -> cur_num sticks at 3, max_num=3 after close.
